// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order word fetches to instruction memory and
// buffers up to two returned instructions in a skid FIFO ahead of IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        Branch_i,
    input  logic [31:0] BranchPC_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] PC_o,
    output logic [31:0] instr_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        kill_q, kill_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_pc_d    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_instr_d [DEPTH];

    logic        resp;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [1:0]  fill;

    assign valid_o     = (count_q != 2'd0);
    assign PC_o        = valid_o ? fifo_pc_q[0] : 32'h0;
    assign instr_o     = valid_o ? fifo_instr_q[0] : 32'h0;
    assign imem_req_o  = issue;
    assign imem_addr_o = pc_q;

    // A live in-flight fetch already owns a FIFO slot, so only issue when one is left over.
    always_comb begin
        resp      = imem_rvalid_i & outstanding_q;
        pop       = valid_o & ~Stall_i & ~Branch_i;
        push      = resp & ~kill_q & ~Branch_i;
        occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, outstanding_q & ~kill_q};
        issue     = ~Branch_i & ~rst_i & (~outstanding_q | imem_rvalid_i)
                    & (occupancy < 3'(DEPTH));
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        if (issue) begin
            pc_d          = pc_q + 32'd4;
            req_pc_d      = pc_q;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end
        if (resp) begin
            kill_d = 1'b0;
        end
        // A redirect with a fetch still in the air marks that response for discard.
        if (Branch_i) begin
            pc_d = BranchPC_i;
            if (outstanding_q & ~imem_rvalid_i) begin
                kill_d = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        fill         = count_q - {1'b0, pop};
        if (pop) begin
            fifo_pc_d[0]    = fifo_pc_q[1];
            fifo_instr_d[0] = fifo_instr_q[1];
        end
        if (push) begin
            if (fill == 2'd0) begin
                fifo_pc_d[0]    = req_pc_q;
                fifo_instr_d[0] = imem_rdata_i;
            end else begin
                fifo_pc_d[1]    = req_pc_q;
                fifo_instr_d[1] = imem_rdata_i;
            end
        end
        count_d = Branch_i ? 2'd0 : (fill + {1'b0, push});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'h0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            count_q       <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0;
                fifo_instr_q[i] <= 32'h0;
            end
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a variable-latency memory plus a queue-based model of the
// delivered instruction stream; a second instance starts at the top of memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst, rst_w;
    logic        stall, branch;
    logic [31:0] branch_pc;
    logic        rvalid, rvalid_w;
    logic [31:0] rdata, rdata_w;
    logic        req, req_w;
    logic [31:0] addr, addr_w;
    logic        valid, valid_w;
    logic [31:0] pc_out, pc_w;
    logic [31:0] instr, instr_w;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .Stall_i(stall), .Branch_i(branch), .BranchPC_i(branch_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .valid_o(valid), .PC_o(pc_out), .instr_o(instr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk_i(clk), .rst_i(rst_w), .Stall_i(stall), .Branch_i(branch), .BranchPC_i(branch_pc),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
        .valid_o(valid_w), .PC_o(pc_w), .instr_o(instr_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    logic [31:0] m_fetch_pc;
    logic [31:0] mq [$];
    bit          mem_busy, mem_stale;
    int          mem_wait;
    logic [31:0] mem_addr, mem_model_pc;
    int          lat_min = 1, lat_max = 1;

    logic        o_req, o_valid, e_req, e_valid, s_rvalid;
    logic [31:0] o_addr, o_pc, o_instr, e_addr, e_pc, e_instr;

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = 32'h0;
        mem_busy   = 0;
        mem_stale  = 0;
        mem_wait   = 0;
    endtask

    // One clock: drive inputs, sample outputs mid-cycle, predict, then advance the model.
    task automatic step(input logic st, input logic br, input logic [31:0] bpc);
        int sz;
        bit pop_e, live;
        @(negedge clk);
        stall     = st;
        branch    = br;
        branch_pc = bpc;
        rvalid    = mem_busy && (mem_wait == 0);
        rdata     = rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
        s_rvalid = rvalid;
        o_req    = req;
        o_addr   = addr;
        o_valid  = valid;
        o_pc     = pc_out;
        o_instr  = instr;
        sz       = mq.size();
        e_valid  = (sz != 0);
        e_pc     = e_valid ? mq[0] : 32'h0;
        e_instr  = e_valid ? mem_word(mq[0]) : 32'h0;
        pop_e    = e_valid && !st && !br;
        live     = mem_busy && !mem_stale;
        e_req    = !br && (!mem_busy || rvalid) && ((sz - int'(pop_e) + int'(live)) < 2);
        e_addr   = m_fetch_pc;
        @(posedge clk);
        if (rvalid) begin
            if (!mem_stale && !br) mq.push_back(mem_model_pc);
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (br) begin
            mq.delete();
            m_fetch_pc = bpc;
            if (mem_busy) mem_stale = 1;
        end else if (pop_e) begin
            void'(mq.pop_front());
        end
        if (o_req) begin
            mem_busy     = 1;
            mem_stale    = 0;
            mem_addr     = o_addr;
            mem_model_pc = m_fetch_pc;
            mem_wait     = int'($urandom_range(lat_max, lat_min)) - 1;
            m_fetch_pc   = m_fetch_pc + 32'd4;
        end
    endtask

    task automatic test_reset();
        rst = 1; rst_w = 1; stall = 0; branch = 0; branch_pc = 0;
        rvalid = 0; rdata = 0; rvalid_w = 0; rdata_w = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h want 0", pc_out); end
        checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b want 0", req); end
        checks++; if (req_w !== 1'b0 || valid_w !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap: req %b valid %b want 0 0", req_w, valid_w); end
    endtask

    task automatic test_wrap();
        @(posedge clk); #2; rst_w = 0;
        @(negedge clk); #1;
        checks++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_req0: req %b addr %h want 1 fffffffc", req_w, addr_w); end
        @(negedge clk); rvalid_w = 1; rdata_w = mem_word(32'hFFFF_FFFC); #1;
        checks++; if (req_w !== 1'b1 || addr_w !== 32'h0) begin failures++; $display("[TB] FAIL wrap_req1: req %b addr %h want 1 00000000", req_w, addr_w); end
        @(negedge clk); rvalid_w = 1; rdata_w = mem_word(32'h0); #1;
        checks++; if (valid_w !== 1'b1 || pc_w !== 32'hFFFF_FFFC || instr_w !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("[TB] FAIL wrap_head0: valid %b pc %h instr %h want 1 fffffffc", valid_w, pc_w, instr_w); end
        @(negedge clk); rvalid_w = 0; #1;
        checks++; if (valid_w !== 1'b1 || pc_w !== 32'h0 || instr_w !== mem_word(32'h0)) begin failures++; $display("[TB] FAIL wrap_head1: valid %b pc %h instr %h want 1 00000000", valid_w, pc_w, instr_w); end
        rst_w = 1;
    endtask

    task automatic test_throughput();
        model_reset();
        lat_min = 1; lat_max = 1;
        @(posedge clk); #2; rst = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 32'h0);
            checks++; if (o_req !== 1'b1 || o_addr !== 32'(4 * k)) begin failures++; $display("[TB] FAIL tput_req%0d: req %b addr %h want 1 %h", k, o_req, o_addr, 32'(4 * k)); end
            checks++; if (o_valid !== (k >= 2)) begin failures++; $display("[TB] FAIL tput_valid%0d: got %b want %b", k, o_valid, (k >= 2)); end
            if (k >= 2) begin
                checks++; if (o_pc !== 32'(4 * (k - 2)) || o_instr !== mem_word(32'(4 * (k - 2)))) begin failures++; $display("[TB] FAIL tput_head%0d: pc %h instr %h want %h", k, o_pc, o_instr, 32'(4 * (k - 2))); end
            end
        end
    endtask

    task automatic test_stall();
        for (int s = 0; s < 4; s++) begin
            step(1, 0, 32'h0);
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h10) begin failures++; $display("[TB] FAIL stall_hold%0d: valid %b pc %h want 1 00000010", s, o_valid, o_pc); end
            checks++; if (o_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req%0d: got %b want 0", s, o_req); end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 32'h0);
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h10 + 32'(4 * i) || o_instr !== mem_word(32'h10 + 32'(4 * i))) begin failures++; $display("[TB] FAIL stall_resume%0d: valid %b pc %h want 1 %h", i, o_valid, o_pc, 32'h10 + 32'(4 * i)); end
        end
    endtask

    task automatic test_branch_midflight();
        int  guard;
        bit  seen_req, got_valid;
        lat_min = 3; lat_max = 3;
        guard = 0;
        while (!(mem_busy && mem_wait > 0) && guard < 20) begin step(0, 0, 32'h0); guard++; end
        checks++; if (guard >= 20) begin failures++; $display("[TB] FAIL bmid_setup: no in-flight fetch after %0d cycles, want < 20", guard); end
        step(0, 1, 32'h100);
        checks++; if (o_req !== 1'b0) begin failures++; $display("[TB] FAIL bmid_noissue: got %b want 0", o_req); end
        seen_req = 0; got_valid = 0;
        for (int c = 0; c < 12 && !got_valid; c++) begin
            step(0, 0, 32'h0);
            if (c == 0) begin
                checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL bmid_flush: got %b want 0", o_valid); end
            end
            if (o_req && !seen_req) begin
                seen_req = 1;
                checks++; if (o_addr !== 32'h100 || s_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL bmid_target: addr %h rvalid %b want 00000100 1", o_addr, s_rvalid); end
            end
            if (o_valid && !got_valid) begin
                got_valid = 1;
                checks++; if (o_pc !== 32'h100 || o_instr !== mem_word(32'h100)) begin failures++; $display("[TB] FAIL bmid_first: pc %h instr %h want 00000100", o_pc, o_instr); end
            end
        end
        checks++; if (!got_valid) begin failures++; $display("[TB] FAIL bmid_timeout: valid %b want 1 within 12 cycles", o_valid); end
    endtask

    task automatic test_branch_vs_response();
        int guard;
        bit got_valid;
        lat_min = 2; lat_max = 2;
        guard = 0;
        while (!(mem_busy && mem_wait == 0 && !mem_stale) && guard < 20) begin step(0, 0, 32'h0); guard++; end
        checks++; if (guard >= 20) begin failures++; $display("[TB] FAIL bresp_setup: no live response after %0d cycles, want < 20", guard); end
        lat_min = 1; lat_max = 1;
        step(1, 1, 32'h200);
        checks++; if (o_req !== 1'b0) begin failures++; $display("[TB] FAIL bresp_noissue: got %b want 0", o_req); end
        step(0, 0, 32'h0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL bresp_drop: valid %b want 0", o_valid); end
        checks++; if (o_req !== 1'b1 || o_addr !== 32'h200) begin failures++; $display("[TB] FAIL bresp_target: req %b addr %h want 1 00000200", o_req, o_addr); end
        got_valid = 0;
        for (int c = 0; c < 6 && !got_valid; c++) begin
            step(0, 0, 32'h0);
            if (o_valid) begin
                got_valid = 1;
                checks++; if (o_pc !== 32'h200 || o_instr !== mem_word(32'h200)) begin failures++; $display("[TB] FAIL bresp_first: pc %h instr %h want 00000200", o_pc, o_instr); end
            end
        end
        checks++; if (!got_valid) begin failures++; $display("[TB] FAIL bresp_timeout: valid %b want 1 within 6 cycles", o_valid); end
    endtask

    task automatic test_random();
        logic        st, br;
        logic [31:0] bpc;
        lat_min = 1; lat_max = 4;
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom_range(9, 0) < 3);
            br  = ($urandom_range(15, 0) == 0);
            bpc = {$urandom_range(32'hFFFF_FFFF, 0)} & 32'hFFFF_FFFC;
            step(st, br, bpc);
            checks++; if (o_req !== e_req) begin failures++; $display("[TB] FAIL rand_req@%0d: got %b want %b", c, o_req, e_req); end
            if (e_req) begin
                checks++; if (o_addr !== e_addr) begin failures++; $display("[TB] FAIL rand_addr@%0d: got %h want %h", c, o_addr, e_addr); end
            end
            checks++; if (o_valid !== e_valid) begin failures++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", c, o_valid, e_valid); end
            checks++; if (o_pc !== e_pc || o_instr !== e_instr) begin failures++; $display("[TB] FAIL rand_head@%0d: pc %h instr %h want %h %h", c, o_pc, o_instr, e_pc, e_instr); end
        end
    endtask

    task automatic test_reset_midfetch();
        int guard;
        bit got_valid;
        lat_min = 5; lat_max = 5;
        step(0, 1, 32'h300);
        guard = 0;
        while (!(mq.size() >= 1 && mem_busy && !mem_stale && mem_wait >= 2) && guard < 60) begin step(1, 0, 32'h0); guard++; end
        checks++; if (guard >= 60) begin failures++; $display("[TB] FAIL rmid_setup: no buffered+pending state after %0d cycles, want < 60", guard); end
        @(negedge clk); stall = 1; rvalid = 0; #2; rst = 1; #1;
        checks++; if (valid !== 1'b0 || pc_out !== 32'h0 || instr !== 32'h0 || req !== 1'b0) begin failures++; $display("[TB] FAIL rmid_async: valid %b pc %h instr %h req %b want 0", valid, pc_out, instr, req); end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rvalid = (i == 1); rdata = mem_word(32'h304); #1;
            checks++; if (valid !== 1'b0 || req !== 1'b0) begin failures++; $display("[TB] FAIL rmid_hold%0d: valid %b req %b want 0 0", i, valid, req); end
        end
        @(negedge clk); rvalid = 0; stall = 0;
        lat_min = 1; lat_max = 1;
        @(posedge clk); #2; rst = 0;
        step(0, 0, 32'h0);
        checks++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin failures++; $display("[TB] FAIL rmid_restart: req %b addr %h want 1 00000000", o_req, o_addr); end
        got_valid = 0;
        for (int c = 0; c < 8 && !got_valid; c++) begin
            step(0, 0, 32'h0);
            if (o_valid) begin
                got_valid = 1;
                checks++; if (o_pc !== 32'h0 || o_instr !== mem_word(32'h0)) begin failures++; $display("[TB] FAIL rmid_first: pc %h instr %h want 00000000", o_pc, o_instr); end
            end
        end
        checks++; if (!got_valid) begin failures++; $display("[TB] FAIL rmid_timeout: valid %b want 1 within 8 cycles", o_valid); end
    endtask

    task automatic test_spurious_response();
        int guard;
        guard = 0;
        while (!(mq.size() == 2 && !mem_busy) && guard < 10) begin step(1, 0, 32'h0); guard++; end
        checks++; if (guard >= 10) begin failures++; $display("[TB] FAIL spur_setup: FIFO not full after %0d cycles, want < 10", guard); end
        @(negedge clk); stall = 1; branch = 0; rvalid = 1; rdata = 32'h1234_5678; #1;
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL spur_req: got %b want 0", req); end
        @(posedge clk);
        step(1, 0, 32'h0);
        checks++; if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin failures++; $display("[TB] FAIL spur_head: pc %h instr %h want %h %h", o_pc, o_instr, e_pc, e_instr); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0);
            checks++; if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin failures++; $display("[TB] FAIL spur_drain%0d: valid %b pc %h instr %h want %b %h %h", i, o_valid, o_pc, o_instr, e_valid, e_pc, e_instr); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_throughput();
        test_stall();
        test_branch_midflight();
        test_branch_vs_response();
        test_random();
        test_reset_midfetch();
        test_spurious_response();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
